// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared types and constants for the pipeline control blocks.
//   hc_state_t  - hazard_control sequencer states
//   STALL_CNT_W - width of the stall cycle counter
//   REG_W       - register specifier width
package cpu_types_pkg;

    localparam int unsigned STALL_CNT_W = 16;
    localparam int unsigned REG_W       = 5;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LDUSE  = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } hc_state_t;

endpackage

// File: rtl/hazard_control_if.sv
// hazard_control_if: bundles the hazard_control signals for the pipeline top.
//   hc modport - the hazard unit's view: hazard/status inputs in,
//                latch enables/flushes, halt and stall_cnt out.
interface hazard_control_if;
    import cpu_types_pkg::*;

    logic                   ihit;
    logic                   dhit;
    logic                   mem_dREN;
    logic                   mem_dWEN;
    logic                   ex_MemtoReg;
    logic [REG_W-1:0]       ex_WrDest;
    logic [REG_W-1:0]       id_rs;
    logic [REG_W-1:0]       id_rt;
    logic                   ex_branch_taken;
    logic                   id_jump;
    logic                   mem_halt;
    logic                   pc_en;
    logic                   ifid_en;
    logic                   idex_en;
    logic                   exmem_en;
    logic                   memwb_en;
    logic                   ifid_flush;
    logic                   idex_flush;
    logic                   exmem_flush;
    logic                   memwb_flush;
    logic                   halt;
    logic [STALL_CNT_W-1:0] stall_cnt;

    modport hc (
        input  ihit, dhit, mem_dREN, mem_dWEN, ex_MemtoReg, ex_WrDest,
               id_rs, id_rt, ex_branch_taken, id_jump, mem_halt,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, memwb_flush,
               halt, stall_cnt
    );

endinterface

// File: rtl/lduse_detect.sv
// lduse_detect: pure comparator flagging a load in EX whose destination is
// read by the instruction in ID. Register 0 never creates a dependency.
//   ex_MemtoReg, ex_WrDest - load in EX and its destination
//   id_rs, id_rt           - ID source registers
//   lduse                  - dependency present
module lduse_detect
    import cpu_types_pkg::*;
(
    input  logic             ex_MemtoReg,
    input  logic [REG_W-1:0] ex_WrDest,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    output logic             lduse
);

    assign lduse = ex_MemtoReg && (ex_WrDest != '0) &&
                   ((ex_WrDest == id_rs) || (ex_WrDest == id_rt));

endmodule

// File: rtl/hazard_control.sv
// hazard_control: pipeline stall/flush sequencer.
//   CLK, nRST             - clock, async active-low reset
//   ihit, dhit            - fetch / data access complete
//   mem_dREN, mem_dWEN    - load/store in MEM
//   ex_MemtoReg,ex_WrDest - load in EX and its destination
//   id_rs, id_rt          - ID source registers
//   ex_branch_taken       - taken branch resolved in EX
//   id_jump               - jump decoded in ID
//   mem_halt              - halt in MEM
//   pc_en, *_en           - PC and pipeline latch enables
//   *_flush               - bubble insertion per latch
//   halt                  - processor halted
//   stall_cnt             - saturating count of non-halted pc_en=0 cycles
module hazard_control
    import cpu_types_pkg::*;
(
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   ihit,
    input  logic                   dhit,
    input  logic                   mem_dREN,
    input  logic                   mem_dWEN,
    input  logic                   ex_MemtoReg,
    input  logic [REG_W-1:0]       ex_WrDest,
    input  logic [REG_W-1:0]       id_rs,
    input  logic [REG_W-1:0]       id_rt,
    input  logic                   ex_branch_taken,
    input  logic                   id_jump,
    input  logic                   mem_halt,
    output logic                   pc_en,
    output logic                   ifid_en,
    output logic                   idex_en,
    output logic                   exmem_en,
    output logic                   memwb_en,
    output logic                   ifid_flush,
    output logic                   idex_flush,
    output logic                   exmem_flush,
    output logic                   memwb_flush,
    output logic                   halt,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    hc_state_t state, next_state;
    logic      memwait;
    logic      lduse;

    assign memwait = (mem_dREN || mem_dWEN) && !dhit;

    lduse_detect u_lduse_detect (
        .ex_MemtoReg (ex_MemtoReg),
        .ex_WrDest   (ex_WrDest),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .lduse       (lduse)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // RUN and LDUSE share one priority chain; LDUSE only skips the
    // load-use check so the stalled instruction is released after one cycle.
    always_comb begin
        next_state  = state;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;

        unique case (state)
            RUN, LDUSE: begin
                if (memwait) begin
                    memwb_flush = 1'b1;
                end else if (mem_halt) begin
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                    memwb_en    = 1'b1;
                    next_state  = DRAIN;
                end else begin
                    next_state = RUN;
                    if (ex_branch_taken) begin
                        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '1;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (lduse && (state == RUN)) begin
                        idex_en    = 1'b1;
                        idex_flush = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                        next_state = LDUSE;
                    end else if (id_jump) begin
                        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '1;
                        ifid_flush = 1'b1;
                    end else if (!ihit) begin
                        {ifid_en, idex_en, exmem_en, memwb_en} = '1;
                        ifid_flush = 1'b1;
                    end else begin
                        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '1;
                    end
                end
            end
            DRAIN: begin
                memwb_en   = 1'b1;
                next_state = HALTED;
            end
            HALTED: begin
                next_state = HALTED;
            end
            default: begin
                next_state = RUN;
            end
        endcase
    end

    assign halt = (state == HALTED);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt <= '0;
        end else if (!pc_en && (state != HALTED) && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_control.sv
module tb_hazard_control;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit, dhit, mem_dREN, mem_dWEN, ex_MemtoReg;
    logic [4:0]  ex_WrDest, id_rs, id_rt;
    logic        ex_branch_taken, id_jump, mem_halt;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, exmem_flush, memwb_flush, halt;
    logic [15:0] stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    hazard_control dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .ex_MemtoReg(ex_MemtoReg),
        .ex_WrDest(ex_WrDest), .id_rs(id_rs), .id_rt(id_rt),
        .ex_branch_taken(ex_branch_taken), .id_jump(id_jump), .mem_halt(mem_halt),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .memwb_flush(memwb_flush), .halt(halt),
        .stall_cnt(stall_cnt)
    );

    always #5 CLK = ~CLK;

    // {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    //  ifid_flush, idex_flush, exmem_flush, memwb_flush, halt}
    logic [9:0] outv;
    assign outv = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                   ifid_flush, idex_flush, exmem_flush, memwb_flush, halt};

    // {ihit, dhit, dREN, dWEN, MemtoReg, WrDest, rs, rt, branch, jump, mem_halt}
    typedef struct {
        string      name;
        logic       ihit, dhit, dren, dwen, m2r;
        logic [4:0] wd, rs, rt;
        logic       br, jmp, mh;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        ihit = 1'b1; dhit = 1'b0; mem_dREN = 1'b0; mem_dWEN = 1'b0;
        ex_MemtoReg = 1'b0; ex_WrDest = '0; id_rs = '0; id_rt = '0;
        ex_branch_taken = 1'b0; id_jump = 1'b0; mem_halt = 1'b0;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        idle_inputs();
        step();
        nRST = 1'b1;
        #1;
    endtask

    task automatic apply(input vec_t v);
        ihit = v.ihit; dhit = v.dhit; mem_dREN = v.dren; mem_dWEN = v.dwen;
        ex_MemtoReg = v.m2r; ex_WrDest = v.wd; id_rs = v.rs; id_rt = v.rt;
        ex_branch_taken = v.br; id_jump = v.jmp; mem_halt = v.mh;
    endtask

    initial begin
        vecs.push_back('{"idle",        1,0,0,0,0, 0,0,0, 0,0,0, 10'b1111100000});
        vecs.push_back('{"ifetch_miss", 0,0,0,0,0, 0,0,0, 0,0,0, 10'b0111110000});
        vecs.push_back('{"load_miss",   1,0,1,0,0, 0,0,0, 0,0,0, 10'b0000000010});
        vecs.push_back('{"store_miss_br",1,0,0,1,0, 0,0,0, 1,0,0, 10'b0000000010});
        vecs.push_back('{"load_hit",    1,1,1,0,0, 0,0,0, 0,0,0, 10'b1111100000});
        vecs.push_back('{"branch",      1,0,0,0,0, 0,0,0, 1,0,0, 10'b1111111000});
        vecs.push_back('{"jump",        1,0,0,0,0, 0,0,0, 0,1,0, 10'b1111110000});
        vecs.push_back('{"branch_lduse",1,0,0,0,1, 8,8,0, 1,0,0, 10'b1111111000});
        vecs.push_back('{"lduse_r0",    1,0,0,0,1, 0,0,0, 0,0,0, 10'b1111100000});
        vecs.push_back('{"ld_nomatch",  1,0,0,0,1, 9,8,3, 0,0,0, 10'b1111100000});
        vecs.push_back('{"jump_imiss",  0,0,0,0,0, 0,0,0, 0,1,0, 10'b1111110000});
        vecs.push_back('{"noload_match",1,0,0,0,0, 8,8,8, 0,0,0, 10'b1111100000});

        // reset state: outputs follow RUN while reset is held
        nRST = 1'b0;
        idle_inputs();
        #2;
        chk("reset_outputs", 32'(outv), 32'(10'b1111100000));
        chk("reset_cnt", 32'(stall_cnt), 0);
        do_reset();

        // single-cycle vectors from RUN; none of them leaves RUN
        foreach (vecs[i]) begin
            apply(vecs[i]);
            #1;
            chk(vecs[i].name, 32'(outv), 32'(vecs[i].exp));
            step();
            chk({vecs[i].name, "_state"}, 32'(dut.state), 32'(RUN));
        end
        idle_inputs();
        chk("table_stall_cnt", 32'(stall_cnt), 3);

        // load-use: one stall, LDUSE for one cycle, back to RUN
        do_reset();
        ex_MemtoReg = 1'b1; ex_WrDest = 5'd8; id_rs = 5'd8;
        #1;
        chk("lduse_c0_pc_en", 32'(pc_en), 0);
        chk("lduse_c0_ifid_en", 32'(ifid_en), 0);
        chk("lduse_c0_idex_flush", 32'(idex_flush), 1);
        step();
        chk("lduse_c1_state", 32'(dut.state), 32'(LDUSE));
        chk("lduse_c1_pc_en", 32'(pc_en), 1);
        chk("lduse_c1_idex_flush", 32'(idex_flush), 0);
        step();
        idle_inputs();
        #1;
        chk("lduse_c2_state", 32'(dut.state), 32'(RUN));
        chk("lduse_cnt", 32'(stall_cnt), 1);

        // memwait inside LDUSE holds LDUSE
        do_reset();
        ex_MemtoReg = 1'b1; ex_WrDest = 5'd4; id_rt = 5'd4;
        step();
        mem_dWEN = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("ldwait_out", 32'(outv), 32'(10'b0000000010));
            step();
            chk("ldwait_state", 32'(dut.state), 32'(LDUSE));
        end
        dhit = 1'b1;
        #1;
        chk("ldwait_release", 32'(outv), 32'(10'b1111100000));
        step();
        idle_inputs();
        chk("ldwait_run", 32'(dut.state), 32'(RUN));
        chk("ldwait_cnt", 32'(stall_cnt), 3);

        // data miss for 3 cycles
        do_reset();
        mem_dREN = 1'b1; dhit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("dmiss_out", 32'(outv), 32'(10'b0000000010));
            step();
        end
        dhit = 1'b1;
        #1;
        chk("dmiss_done", 32'(outv), 32'(10'b1111100000));
        step();
        idle_inputs();
        chk("dmiss_cnt", 32'(stall_cnt), 3);

        // halt: halt cycle, DRAIN, then HALTED with counter frozen
        mem_halt = 1'b1;
        #1;
        chk("halt_c0", 32'(outv), 32'(10'b0000111100));
        step();
        mem_halt = 1'b0;
        #1;
        chk("drain_state", 32'(dut.state), 32'(DRAIN));
        chk("drain_out", 32'(outv), 32'(10'b0000100000));
        step();
        ex_branch_taken = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("halted_out", 32'(outv), 32'(10'b0000000001));
            chk("halted_cnt", 32'(stall_cnt), 5);
            step();
        end
        idle_inputs();

        // asynchronous reset mid-HALTED
        #1;
        nRST = 1'b0;
        #1;
        chk("arst_halt", 32'(halt), 0);
        chk("arst_state", 32'(dut.state), 32'(RUN));
        chk("arst_cnt", 32'(stall_cnt), 0);
        chk("arst_out", 32'(outv), 32'(10'b1111100000));
        step();
        nRST = 1'b1;
        step();
        chk("post_reset_run", 32'(outv), 32'(10'b1111100000));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
